// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 agent types: response-ordering modes, BRESP codes and the
// entry record used by the slave write-response scheduler.
package axi4_globals_pkg;

    localparam int OUTSTANDING_FIFO_DEPTH = 16;
    localparam int AXI4_MAX_ID_WIDTH      = 16;

    typedef enum logic [1:0] {
        RESP_IN_ORDER                = 2'd0,
        ONLY_READ_RESP_OUT_OF_ORDER  = 2'd1,
        ONLY_WRITE_RESP_OUT_OF_ORDER = 2'd2,
        WRITE_READ_RESP_OUT_OF_ORDER = 2'd3
    } response_mode_e;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'd0,
        BRESP_EXOKAY = 2'd1,
        BRESP_SLVERR = 2'd2,
        BRESP_DECERR = 2'd3
    } bresp_e;

    // IDs are stored zero-extended so one record type serves any ID_WIDTH up to the max.
    typedef struct packed {
        logic [AXI4_MAX_ID_WIDTH-1:0] id;
        logic                         done;
        bresp_e                       resp;
    } bresp_sched_entry_s;

    function automatic logic is_write_ooo(response_mode_e mode);
        return (mode == ONLY_WRITE_RESP_OUT_OF_ORDER) ||
               (mode == WRITE_READ_RESP_OUT_OF_ORDER);
    endfunction

endpackage

// File: rtl/axi4_oldest_done_picker.sv
// Combinational priority encoder: index of the lowest set request bit,
// i.e. the oldest qualifying entry of an age-ordered queue.
module axi4_oldest_done_picker #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi4_slave_bresp_scheduler.sv
// AXI4 slave B-channel scheduler: tracks accepted AW in a compacting age queue
// and returns BID/BRESP in AW order or out of order across IDs.
module axi4_slave_bresp_scheduler
    import axi4_globals_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = OUTSTANDING_FIFO_DEPTH,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [1:0]           resp_mode,
    input  logic                 aw_push_valid,
    output logic                 aw_push_ready,
    input  logic [ID_WIDTH-1:0]  aw_push_id,
    input  logic                 done_valid,
    input  logic [ID_WIDTH-1:0]  done_id,
    input  logic [1:0]           done_resp,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [ID_WIDTH-1:0]  b_id,
    output logic [1:0]           b_resp,
    output logic [CNT_WIDTH-1:0] outstanding_cnt,
    output logic                 err_orphan_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bresp_sched_entry_s queue_reg  [DEPTH];
    bresp_sched_entry_s queue_next [DEPTH];
    bresp_sched_entry_s marked     [DEPTH+1];

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, wr_idx;
    logic [DEPTH-1:0]     live_vec, match_vec, done_vec, elig_vec;
    logic                 match_found, elig_found;
    logic [IDX_W-1:0]     match_idx, pop_idx;
    logic                 push, pop, in_order;
    logic                 b_valid_reg, orphan_reg;
    logic [ID_WIDTH-1:0]  b_id_reg;
    logic [1:0]           b_resp_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign live_vec[gi]  = CNT_WIDTH'(gi) < cnt_reg;
            assign done_vec[gi]  = live_vec[gi] && queue_reg[gi].done;
            assign match_vec[gi] = done_valid && live_vec[gi] && !queue_reg[gi].done &&
                                   (queue_reg[gi].id == AXI4_MAX_ID_WIDTH'(done_id));
        end
    endgenerate

    assign in_order = !is_write_ooo(response_mode_e'(resp_mode));
    assign elig_vec = done_vec & (in_order ? DEPTH'(1) : {DEPTH{1'b1}});

    axi4_oldest_done_picker #(.N(DEPTH), .IDX_W(IDX_W)) u_done_match (
        .req   (match_vec),
        .found (match_found),
        .idx   (match_idx)
    );

    axi4_oldest_done_picker #(.N(DEPTH), .IDX_W(IDX_W)) u_elig_pick (
        .req   (elig_vec),
        .found (elig_found),
        .idx   (pop_idx)
    );

    assign aw_push_ready = cnt_reg < CNT_WIDTH'(DEPTH);
    assign push          = aw_push_valid && aw_push_ready;
    assign pop           = (!b_valid_reg || b_ready) && elig_found;
    assign cnt_next      = cnt_reg + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    assign wr_idx        = cnt_reg - CNT_WIDTH'(pop);

    // Completion marking uses pre-edge indices, so apply it before compaction.
    always_comb begin
        marked[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            marked[i] = queue_reg[i];
            if (match_found && match_idx == IDX_W'(i)) begin
                marked[i].done = 1'b1;
                marked[i].resp = bresp_e'(done_resp);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            queue_next[i] = marked[i];
            if (pop && IDX_W'(i) >= pop_idx) begin
                queue_next[i] = marked[i+1];
            end
            if (push && CNT_WIDTH'(i) == wr_idx) begin
                queue_next[i] = '{id: AXI4_MAX_ID_WIDTH'(aw_push_id), done: 1'b0, resp: BRESP_OKAY};
            end else if (CNT_WIDTH'(i) >= cnt_next) begin
                queue_next[i] = '0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_reg[i] <= '0;
            end
            cnt_reg     <= '0;
            b_valid_reg <= 1'b0;
            b_id_reg    <= '0;
            b_resp_reg  <= '0;
            orphan_reg  <= 1'b0;
        end else begin
            queue_reg  <= queue_next;
            cnt_reg    <= cnt_next;
            orphan_reg <= done_valid && !match_found;
            if (pop) begin
                b_valid_reg <= 1'b1;
                b_id_reg    <= queue_reg[pop_idx].id[ID_WIDTH-1:0];
                b_resp_reg  <= queue_reg[pop_idx].resp;
            end else if (b_ready) begin
                b_valid_reg <= 1'b0;
            end
        end
    end

    assign b_valid         = b_valid_reg;
    assign b_id            = b_id_reg;
    assign b_resp          = b_resp_reg;
    assign outstanding_cnt = cnt_reg;
    assign err_orphan_done = orphan_reg;

endmodule

// File: tb/tb_axi4_slave_bresp_scheduler.sv
// Bench for the B-channel scheduler: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_axi4_slave_bresp_scheduler;
    import axi4_globals_pkg::*;

    localparam int DEPTH = 16;

    logic       aclk = 1'b0;
    logic       areset;
    logic [1:0] resp_mode;
    logic       aw_push_valid;
    logic       aw_push_ready;
    logic [3:0] aw_push_id;
    logic       done_valid;
    logic [3:0] done_id;
    logic [1:0] done_resp;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_id;
    logic [1:0] b_resp;
    logic [4:0] outstanding_cnt;
    logic       err_orphan_done;

    axi4_slave_bresp_scheduler #(.ID_WIDTH(4), .DEPTH(DEPTH)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .resp_mode       (resp_mode),
        .aw_push_valid   (aw_push_valid),
        .aw_push_ready   (aw_push_ready),
        .aw_push_id      (aw_push_id),
        .done_valid      (done_valid),
        .done_id         (done_id),
        .done_resp       (done_resp),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_id            (b_id),
        .b_resp          (b_resp),
        .outstanding_cnt (outstanding_cnt),
        .err_orphan_done (err_orphan_done)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: outstanding writes as a plain age-ordered queue.
    typedef struct packed {
        logic [3:0] id;
        logic       done;
        logic [1:0] resp;
    } ment_t;

    ment_t      mq[$];
    logic       m_bv;
    logic [3:0] m_bid;
    logic [1:0] m_bresp;
    logic       m_orphan;

    typedef struct packed {
        logic [1:0] mode;
        logic       aw_v;
        logic [3:0] aw_id;
        logic       d_v;
        logic [3:0] d_id;
        logic [1:0] d_resp;
        logic       exp_bv;
        logic [3:0] exp_bid;
        logic [1:0] exp_bresp;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_bv     = 1'b0;
        m_bid    = '0;
        m_bresp  = '0;
        m_orphan = 1'b0;
    endfunction

    function automatic void model_step();
        int  sel = -1;
        int  hit = -1;
        bit  ooo;
        bit  push;
        bit  pop;
        ooo  = (resp_mode == ONLY_WRITE_RESP_OUT_OF_ORDER) ||
               (resp_mode == WRITE_READ_RESP_OUT_OF_ORDER);
        push = aw_push_valid && (mq.size() < DEPTH);
        if (ooo) begin
            foreach (mq[i]) if (sel < 0 && mq[i].done) sel = i;
        end else if (mq.size() > 0 && mq[0].done) begin
            sel = 0;
        end
        pop = (!m_bv || b_ready) && (sel >= 0);
        if (done_valid) begin
            foreach (mq[i]) if (hit < 0 && !mq[i].done && mq[i].id == done_id) hit = i;
        end
        m_orphan = done_valid && (hit < 0);
        if (hit >= 0) begin
            mq[hit].done = 1'b1;
            mq[hit].resp = done_resp;
        end
        if (pop) begin
            m_bv    = 1'b1;
            m_bid   = mq[sel].id;
            m_bresp = mq[sel].resp;
            mq.delete(sel);
        end else if (b_ready) begin
            m_bv = 1'b0;
        end
        if (push) mq.push_back('{id: aw_push_id, done: 1'b0, resp: 2'd0});
    endfunction

    task automatic cycle();
        if (b_valid && b_ready)
            $display("B beat: id=%0d resp=%0d cnt=%0d t=%0t", b_id, b_resp, outstanding_cnt, $time);
        model_step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic aw_v, input logic [3:0] aw_id, input logic d_v,
                         input logic [3:0] d_id, input logic [1:0] d_resp, input logic rdy);
        aw_push_valid = aw_v;
        aw_push_id    = aw_id;
        done_valid    = d_v;
        done_id       = d_id;
        done_resp     = d_resp;
        b_ready       = rdy;
        cycle();
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        aw_push_valid = 1'b0;
        done_valid    = 1'b0;
        b_ready       = 1'b1;
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic check_model();
        check("b_valid", 32'(b_valid), 32'(m_bv));
        if (m_bv) begin
            check("b_id", 32'(b_id), 32'(m_bid));
            check("b_resp", 32'(b_resp), 32'(m_bresp));
        end
        check("cnt", 32'(outstanding_cnt), 32'(mq.size()));
        check("ready", 32'(aw_push_ready), 32'(mq.size() < DEPTH));
        check("orphan", 32'(err_orphan_done), 32'(m_orphan));
    endtask

    function automatic void add_vec(input logic [1:0] mode, input logic aw_v, input logic [3:0] aw_id,
                                    input logic d_v, input logic [3:0] d_id, input logic [1:0] d_resp,
                                    input logic ebv, input logic [3:0] ebid, input logic [1:0] ebr,
                                    input logic [4:0] ecnt);
        vecs.push_back('{mode, aw_v, aw_id, d_v, d_id, d_resp, ebv, ebid, ebr, ecnt});
    endfunction

    initial begin
        areset        = 1'b1;
        resp_mode     = 2'd0;
        aw_push_valid = 1'b0;
        aw_push_id    = '0;
        done_valid    = 1'b0;
        done_id       = '0;
        done_resp     = '0;
        b_ready       = 1'b1;
        model_reset();
        #2;
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_id", 32'(b_id), 32'd0);
        check("rst_b_resp", 32'(b_resp), 32'd0);
        check("rst_cnt", 32'(outstanding_cnt), 32'd0);
        check("rst_orphan", 32'(err_orphan_done), 32'd0);
        check("rst_ready", 32'(aw_push_ready), 32'd1);
        @(negedge aclk);
        areset = 1'b0;

        // In order: push 3,5; done 5 OKAY; done 3 SLVERR
        add_vec(2'd0, 1, 4'd3, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd1);
        add_vec(2'd0, 1, 4'd5, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd0, 0, 4'd0, 1, 4'd5, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd0, 0, 4'd0, 1, 4'd3, 2'd2, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd0, 0, 4'd0, 0, 4'd0, 2'd0, 1, 4'd3, 2'd2, 5'd1);
        add_vec(2'd0, 0, 4'd0, 0, 4'd0, 2'd0, 1, 4'd5, 2'd0, 5'd0);
        add_vec(2'd0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd0);
        // Out of order, same stimulus
        add_vec(2'd2, 1, 4'd3, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd1);
        add_vec(2'd2, 1, 4'd5, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd2, 0, 4'd0, 1, 4'd5, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd2, 0, 4'd0, 1, 4'd3, 2'd2, 1, 4'd5, 2'd0, 5'd1);
        add_vec(2'd2, 0, 4'd0, 0, 4'd0, 2'd0, 1, 4'd3, 2'd2, 5'd0);
        add_vec(2'd2, 0, 4'd0, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd0);
        // Same ID twice, out of order mode
        add_vec(2'd3, 1, 4'd2, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd1);
        add_vec(2'd3, 1, 4'd2, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd3, 0, 4'd0, 1, 4'd2, 2'd0, 0, 4'd0, 2'd0, 5'd2);
        add_vec(2'd3, 0, 4'd0, 1, 4'd2, 2'd3, 1, 4'd2, 2'd0, 5'd1);
        add_vec(2'd3, 0, 4'd0, 0, 4'd0, 2'd0, 1, 4'd2, 2'd3, 5'd0);
        add_vec(2'd3, 0, 4'd0, 0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 5'd0);

        foreach (vecs[k]) begin
            resp_mode = vecs[k].mode;
            drive(vecs[k].aw_v, vecs[k].aw_id, vecs[k].d_v, vecs[k].d_id, vecs[k].d_resp, 1'b1);
            check($sformatf("vec%0d_b_valid", k), 32'(b_valid), 32'(vecs[k].exp_bv));
            if (vecs[k].exp_bv) begin
                check($sformatf("vec%0d_b_id", k), 32'(b_id), 32'(vecs[k].exp_bid));
                check($sformatf("vec%0d_b_resp", k), 32'(b_resp), 32'(vecs[k].exp_bresp));
            end
            check($sformatf("vec%0d_cnt", k), 32'(outstanding_cnt), 32'(vecs[k].exp_cnt));
            check($sformatf("vec%0d_ready", k), 32'(aw_push_ready), 32'd1);
        end

        // Backpressure: id7 held while b_ready is low
        do_reset();
        resp_mode = 2'd0;
        drive(1, 4'd7, 0, 4'd0, 2'd0, 1'b0);
        drive(1, 4'd4, 0, 4'd0, 2'd0, 1'b0);
        drive(0, 4'd0, 1, 4'd7, 2'd0, 1'b0);
        drive(0, 4'd0, 1, 4'd4, 2'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp_b_valid", 32'(b_valid), 32'd1);
            check("bp_b_id", 32'(b_id), 32'd7);
            check("bp_b_resp", 32'(b_resp), 32'd0);
            check("bp_cnt", 32'(outstanding_cnt), 32'd1);
            drive(0, 4'd0, 0, 4'd0, 2'd0, 1'b0);
        end
        drive(0, 4'd0, 0, 4'd0, 2'd0, 1'b1);
        check("bp_next_valid", 32'(b_valid), 32'd1);
        check("bp_next_id", 32'(b_id), 32'd4);
        check("bp_next_resp", 32'(b_resp), 32'd1);
        check("bp_next_cnt", 32'(outstanding_cnt), 32'd0);
        drive(0, 4'd0, 0, 4'd0, 2'd0, 1'b1);
        check("bp_drain_valid", 32'(b_valid), 32'd0);

        // Full queue and orphan done
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 4'(i % 8), 0, 4'd0, 2'd0, 1'b1);
            check("full_cnt", 32'(outstanding_cnt), 32'(i + 1));
        end
        check("full_ready", 32'(aw_push_ready), 32'd0);
        drive(1, 4'd5, 0, 4'd0, 2'd0, 1'b1);
        check("full_17th_cnt", 32'(outstanding_cnt), 32'd16);
        check("full_17th_ready", 32'(aw_push_ready), 32'd0);
        drive(0, 4'd0, 1, 4'd9, 2'd2, 1'b1);
        check("orphan_pulse", 32'(err_orphan_done), 32'd1);
        check("orphan_cnt", 32'(outstanding_cnt), 32'd16);
        drive(0, 4'd0, 0, 4'd0, 2'd0, 1'b1);
        check("orphan_clear", 32'(err_orphan_done), 32'd0);

        // Reset with 4 pending entries and a held B response
        do_reset();
        resp_mode = 2'd2;
        for (int i = 1; i <= 5; i++) drive(1, 4'(i), 0, 4'd0, 2'd0, 1'b0);
        drive(0, 4'd0, 1, 4'd1, 2'd0, 1'b0);
        drive(0, 4'd0, 0, 4'd0, 2'd0, 1'b0);
        check("pre_rst_valid", 32'(b_valid), 32'd1);
        check("pre_rst_cnt", 32'(outstanding_cnt), 32'd4);
        areset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(b_valid), 32'd0);
        check("mid_rst_cnt", 32'(outstanding_cnt), 32'd0);
        check("mid_rst_ready", 32'(aw_push_ready), 32'd1);
        model_reset();
        @(negedge aclk);
        areset = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            ment_t cand[$];
            if (c % 60 == 0) resp_mode = 2'($urandom_range(0, 3));
            aw_push_valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 50 : 80));
            aw_push_id    = 4'($urandom_range(0, 3));
            done_valid    = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 45 : 20));
            done_resp     = 2'($urandom_range(0, 3));
            cand = mq.find(e) with (!e.done);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                done_id = cand[$urandom_range(0, cand.size() - 1)].id;
            else
                done_id = 4'($urandom_range(0, 15));
            b_ready = ($urandom_range(0, 99) < 70);
            cycle();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
